// File: rtl/storage_seq_ctrl_pkg.sv
// rtl/storage_seq_ctrl_pkg.sv - shared state encodings and default widths for the storage controller
package storage_seq_ctrl_pkg;

    // Default geometry, shared with the storage array and the display driver
    localparam int DEF_AW = 3;
    localparam int DEF_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_WRITE  = 3'd2,
        ST_SCAN   = 3'd3,
        ST_VERIFY = 3'd4
    } state_t;

endpackage

// File: rtl/storage_seq_ctrl_if.sv
// rtl/storage_seq_ctrl_if.sv - single write/read port between controller and storage array
interface storage_seq_ctrl_if
    import storage_seq_ctrl_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
    modport slave  (input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/storage_dwell_timer.sv
// rtl/storage_dwell_timer.sv - scan dwell counter, one tick every DWELL running cycles
module storage_dwell_timer #(
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;

    logic [CW-1:0] cnt;

    assign tick = run && (cnt == CW'(DWELL - 1));

    // Count while running, restart after the tick, hold otherwise; clr forces zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: rtl/storage_seq_ctrl.sv
// rtl/storage_seq_ctrl.sv - serialises user writes, clear and auto-scan onto one storage port (option: STORAGE_SEQ_VERIFY_EN)
module storage_seq_ctrl
    import storage_seq_ctrl_pkg::*;
#(
    parameter int          AW    = DEF_AW,
    parameter int          DW    = DEF_DW,
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_req,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    input  logic                clr_req,
    input  logic                scan_en,
    storage_seq_ctrl_if.master  mem,
    output logic [AW-1:0]       disp_addr,
    output logic [DW-1:0]       disp_data,
    output logic                busy,
    output logic                wr_ovf,
    output logic                verr
);
    state_t        state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [AW-1:0] scan_ptr;
    logic          pend;
    logic [AW-1:0] pend_addr;
    logic [DW-1:0] pend_data;
    logic          tick;
    logic          tick_hold;
    logic          scan_req;

    assign busy     = (state != ST_IDLE);
    assign scan_req = tick || tick_hold;

    storage_dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .run  (scan_en && (state == ST_IDLE)),
        .clr  (!scan_en),
        .tick (tick)
    );

`ifdef STORAGE_SEQ_VERIFY_EN
    logic [AW-1:0] vfy_addr;
    logic [DW-1:0] vfy_data;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state and storage port drive; IDLE parks the port on the displayed word
    always_comb begin
        state_nxt     = state;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = disp_addr;
        mem.mem_wdata = '0;
        case (state)
            ST_IDLE: begin
                // wr_req is taken directly so a lone write reaches the port next cycle
                if (clr_req)              state_nxt = ST_CLEAR;
                else if (pend || wr_req)  state_nxt = ST_WRITE;
                else if (scan_req)        state_nxt = ST_SCAN;
            end
            ST_CLEAR: begin
                mem.mem_we   = 1'b1;
                mem.mem_addr = clr_cnt;
                if (clr_cnt == '1) state_nxt = ST_IDLE;
            end
            ST_WRITE: begin
                mem.mem_we    = 1'b1;
                mem.mem_addr  = pend_addr;
                mem.mem_wdata = pend_data;
`ifdef STORAGE_SEQ_VERIFY_EN
                state_nxt     = ST_VERIFY;
`else
                state_nxt     = ST_IDLE;
`endif
            end
            ST_SCAN: begin
                mem.mem_addr = scan_ptr;
                state_nxt    = ST_IDLE;
            end
`ifdef STORAGE_SEQ_VERIFY_EN
            ST_VERIFY: begin
                mem.mem_addr = vfy_addr;
                state_nxt    = ST_IDLE;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

    // One-deep pending write; a newer request overwrites an unconsumed one and flags it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend      <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            wr_ovf    <= 1'b0;
        end else begin
            wr_ovf <= wr_req && pend && (state != ST_WRITE);
            if (wr_req) begin
                pend      <= 1'b1;
                pend_addr <= wr_addr;
                pend_data <= wr_data;
            end else if (state == ST_WRITE) begin
                pend <= 1'b0;
            end
        end
    end

    // Clear counter, scan pointer and display latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt   <= '0;
            scan_ptr  <= '0;
            disp_addr <= '0;
            disp_data <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1) disp_data <= '0;
                end
                ST_WRITE: begin
                    // Keep the display coherent with a write to the shown address
                    if (pend_addr == disp_addr) disp_data <= pend_data;
                end
                ST_SCAN: begin
                    disp_addr <= scan_ptr;
                    disp_data <= mem.mem_rdata;
                    scan_ptr  <= scan_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A scan tick that loses arbitration is remembered until SCAN runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                 tick_hold <= 1'b0;
        else if (!scan_en)                                       tick_hold <= 1'b0;
        else if ((state == ST_IDLE) && (state_nxt == ST_SCAN))   tick_hold <= 1'b0;
        else if (tick)                                           tick_hold <= 1'b1;
    end

`ifdef STORAGE_SEQ_VERIFY_EN
    // Capture the written word, then compare the read-back one cycle later; error is sticky
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vfy_addr <= '0;
            vfy_data <= '0;
            verr     <= 1'b0;
        end else begin
            if (state == ST_WRITE) begin
                vfy_addr <= pend_addr;
                vfy_data <= pend_data;
            end
            if ((state == ST_VERIFY) && (mem.mem_rdata != vfy_data)) verr <= 1'b1;
        end
    end
`else
    assign verr = 1'b0;
`endif
endmodule

// File: tb/tb_storage_seq_ctrl.sv
// tb/tb_storage_seq_ctrl.sv - directed and randomized self-checking bench for storage_seq_ctrl
module tb_storage_seq_ctrl;
    localparam int AW    = 3;
    localparam int DW    = 8;
    localparam int DWELL = 4;
`ifdef STORAGE_SEQ_VERIFY_EN
    localparam int WB = 2;
`else
    localparam int WB = 1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          clr_req = 1'b0;
    logic          scan_en = 1'b0;
    logic [AW-1:0] disp_addr;
    logic [DW-1:0] disp_data;
    logic          busy;
    logic          wr_ovf;
    logic          verr;

    logic          corrupt = 1'b0;
    logic [DW-1:0] smem    [0:7];
    logic [DW-1:0] exp_mem [0:7];
    logic [DW-1:0] exp_disp;
    logic [AW-1:0] exp_daddr;

    int n_cmp = 0;
    int n_bad = 0;
    int ovf_total = 0;

    storage_seq_ctrl_if #(.AW(AW), .DW(DW)) mem_if ();

    storage_seq_ctrl #(.AW(AW), .DW(DW), .DWELL(DWELL)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .clr_req   (clr_req),
        .scan_en   (scan_en),
        .mem       (mem_if),
        .disp_addr (disp_addr),
        .disp_data (disp_data),
        .busy      (busy),
        .wr_ovf    (wr_ovf),
        .verr      (verr)
    );

    always #5 clk = ~clk;

    // External storage: synchronous write, combinational read, optional bit-0 fault
    assign mem_if.mem_rdata = smem[mem_if.mem_addr];
    always @(posedge clk) begin
        if (mem_if.mem_we) smem[mem_if.mem_addr] <= mem_if.mem_wdata ^ {7'b0, corrupt};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ovf_total += int'(wr_ovf);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        step();
        wr_req  = 1'b0;
        repeat (WB) step();
    endtask

    initial begin
        int busy_cnt;
        int ovf_before;
        int w1_cnt;
        logic [DW-1:0] w1_data;
        logic [AW-1:0] a, b;
        logic [DW-1:0] d, e;

        // Reset state
        rst = 1'b1;
        repeat (2) step();
        chk("reset_outs", {6'b0, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata,
                           disp_addr, disp_data, busy, wr_ovf, verr}, 32'h0);
        rst = 1'b0;
        step();

        // 1: write latency of one cycle
        wr_addr = 3'd5; wr_data = 8'hA5; wr_req = 1'b1;
        chk("t1_pre_we", mem_if.mem_we, 0);
        step();
        wr_req = 1'b0;
        chk("t1_we", mem_if.mem_we, 1);
        chk("t1_addr", mem_if.mem_addr, 5);
        chk("t1_data", mem_if.mem_wdata, 8'hA5);
        repeat (WB) step();
        chk("t1_idle", {busy, mem_if.mem_we}, 0);

        // 2: clear wins over a simultaneous write, write follows
        clr_req = 1'b1; wr_addr = 3'd2; wr_data = 8'h3C; wr_req = 1'b1;
        step();
        clr_req = 1'b0; wr_req = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            if (i < 8)
                chk($sformatf("t2_clr%0d", i),
                    {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}, {1'b1, 3'(i), 8'h00});
            if (i == 9)
                chk("t2_write", {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata}, {1'b1, 3'd2, 8'h3C});
            busy_cnt += int'(busy);
            step();
        end
        chk("t2_busy_cycles", busy_cnt, 8 + WB);
        chk("t2_disp_zero", disp_data, 0);
        for (int k = 0; k < 8; k++) exp_mem[k] = '0;
        exp_mem[2] = 8'h3C;

        // 3: two writes during CLEAR, latest wins and overflow pulses once
        ovf_before = ovf_total;
        w1_cnt = 0;
        w1_data = '0;
        for (int i = 0; i < 20; i++) begin
            clr_req = (i == 0);
            wr_req  = (i == 1) || (i == 2);
            wr_addr = 3'd1;
            wr_data = (i == 1) ? 8'h11 : 8'h22;
            if (mem_if.mem_we && mem_if.mem_addr == 3'd1 && mem_if.mem_wdata != 8'h00) begin
                w1_cnt++;
                w1_data = mem_if.mem_wdata;
            end
            step();
        end
        clr_req = 1'b0; wr_req = 1'b0;
        chk("t3_ovf_pulses", ovf_total - ovf_before, 1);
        chk("t3_write_count", w1_cnt, 1);
        chk("t3_write_data", w1_data, 8'h22);
        chk("t3_stored", smem[1], 8'h22);
        for (int k = 0; k < 8; k++) exp_mem[k] = '0;

        // 4: auto-scan over k*0x10, one step every DWELL+1 cycles, then wrap
        for (int k = 0; k < 8; k++) begin
            do_write(3'(k), 8'(k * 16));
            exp_mem[k] = 8'(k * 16);
        end
        scan_en = 1'b1;
        for (int k = 0; k < 9; k++) begin
            repeat (3) step();
            chk($sformatf("t4_idle%0d", k), busy, 0);
            step();
            chk($sformatf("t4_scan%0d", k), busy, 1);
            step();
            chk($sformatf("t4_disp%0d", k), {disp_addr, disp_data}, {3'(k % 8), exp_mem[k % 8]});
        end

        // 5: write to displayed address updates display, dwell frozen while busy
        wr_addr = disp_addr; wr_data = 8'hFF; wr_req = 1'b1;
        exp_mem[0] = 8'hFF;
        step();
        wr_req = 1'b0;
        chk("t5_we", mem_if.mem_we, 1);
        repeat (WB) step();
        chk("t5_disp", disp_data, 8'hFF);
        repeat (2) step();
        chk("t5_still_idle", busy, 0);
        step();
        chk("t5_scan", {busy, mem_if.mem_we, mem_if.mem_addr}, {1'b1, 1'b0, 3'd1});
        step();
        chk("t5_next_disp", {disp_addr, disp_data}, {3'd1, exp_mem[1]});
        scan_en = 1'b0;
        step();

        // Randomized writes, some back-to-back; display coherency and contents via scan
        exp_daddr = disp_addr;
        exp_disp  = exp_mem[1];
        ovf_before = ovf_total;
        for (int i = 0; i < 24; i++) begin
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                b = 3'($urandom_range(0, 7));
                e = 8'($urandom_range(0, 255));
                wr_addr = a; wr_data = d; wr_req = 1'b1;
                step();
                wr_addr = b; wr_data = e;
                step();
                wr_req = 1'b0;
                repeat (2 * WB) step();
                exp_mem[a] = d;
                if (a == exp_daddr) exp_disp = d;
                exp_mem[b] = e;
                if (b == exp_daddr) exp_disp = e;
            end else begin
                do_write(a, d);
                exp_mem[a] = d;
                if (a == exp_daddr) exp_disp = d;
            end
        end
        chk("rnd_no_ovf", ovf_total - ovf_before, 0);
        chk("rnd_disp", {disp_addr, disp_data}, {exp_daddr, exp_disp});
        scan_en = 1'b1;
        for (int k = 0; k < 8; k++) begin
            repeat (5) step();
            chk($sformatf("rnd_scan%0d", k), {disp_addr, disp_data},
                {3'((2 + k) % 8), exp_mem[(2 + k) % 8]});
        end
        scan_en = 1'b0;
        step();

        // 6: verify error (sticky) or verr held low without the option
`ifdef STORAGE_SEQ_VERIFY_EN
        corrupt = 1'b1;
        do_write(3'd3, 8'h5A);
        corrupt = 1'b0;
        exp_mem[3] = 8'h5B;
        chk("t6_verr_set", verr, 1);
        do_write(3'd4, 8'h5A);
        exp_mem[4] = 8'h5A;
        chk("t6_verr_sticky", verr, 1);
`else
        do_write(3'd3, 8'h5A);
        exp_mem[3] = 8'h5A;
        chk("t6_verr_low", verr, 0);
`endif

        // Reset in the middle of CLEAR: immediate return to reset state, partial clear kept
        do_write(3'd7, 8'h77);
        exp_mem[7] = 8'h77;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (2) step();
        chk("t7_pre_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t7_async_outs", {6'b0, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata,
                              disp_addr, disp_data, busy, wr_ovf, verr}, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("t7_idle_after", busy, 0);
        chk("t7_cleared0", smem[0], 8'h00);
        chk("t7_kept2", smem[2], exp_mem[2]);
        chk("t7_kept7", smem[7], 8'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
